mul255_serial: RTL and testbench

MUL255_SERIAL -- requirements
Module: mul255_serial

---
 rtl/mul255_pkg.sv | 34 +++
 rtl/mul255_serial_if.sv | 22 ++
 rtl/mul255_byte_sub.sv | 21 ++
 rtl/mul255_serial.sv | 108 ++++++++++
 tb/tb_mul255_serial.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul255_pkg.sv
// Shared types and constants for the byte-serial multiply-by-255 unit.
// Latency: n/a (package). Backpressure: n/a.
// Contents: state enum, byte/word geometry, done latency, byte-lane helper.
package mul255_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned N_BYTES  = 4;
    localparam int unsigned WORD_W   = BYTE_W * N_BYTES;
    // Cycles from the cycle in which start is sampled to the done cycle.
    localparam int unsigned DONE_LAT = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_B3   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Lowest bit position of the byte lane handled in a byte state.
    function automatic int unsigned byte_lo(input state_t s);
        int unsigned lo;
        lo = 0;
        case (s)
            S_B1:    lo = BYTE_W;
            S_B2:    lo = 2 * BYTE_W;
            S_B3:    lo = 3 * BYTE_W;
            default: lo = 0;
        endcase
        return lo;
    endfunction

endpackage

// File: rtl/mul255_serial_if.sv
// Request/result bundle for mul255_serial; optional ovf with MUL255_OVF_EN.
// Latency: n/a (wiring only). Backpressure: start is ignored while busy.
// master drives start/q and observes busy/done/out(/ovf); slave is the unit.
interface mul255_serial_if;
    import mul255_pkg::*;

    logic              start;
    logic [WORD_W-1:0] q;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] out;
`ifdef MUL255_OVF_EN
    logic              ovf;

    modport master (output start, output q, input busy, input done, input out, input ovf);
    modport slave  (input start, input q, output busy, output done, output out, output ovf);
`else
    modport master (output start, output q, input busy, input done, input out);
    modport slave  (input start, input q, output busy, output done, output out);
`endif

endinterface

// File: rtl/mul255_byte_sub.sv
// 8-bit subtract with borrow: d = a - b - bin, bout = borrow out.
// Latency: combinational. Backpressure: none.
// Ports: a_i, b_i, bin_i in; d_o, bout_o out.
module mul255_byte_sub
    import mul255_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              bin_i,
    output logic [BYTE_W-1:0] d_o,
    output logic              bout_o
);

    logic [BYTE_W:0] diff;

    // One extra bit captures the borrow as the wrapped sign of the result.
    assign diff   = {1'b0, a_i} - {1'b0, b_i} - {{BYTE_W{1'b0}}, bin_i};
    assign d_o    = diff[BYTE_W-1:0];
    assign bout_o = diff[BYTE_W];

endmodule

// File: rtl/mul255_serial.sv
// Computes out = q*255 mod 2^32 as (q<<8) - q, one byte lane per cycle.
// Latency: done 5 cycles after the start-sample cycle; one IDLE cycle between ops.
// Backpressure: start only accepted in IDLE; busy high otherwise. Option: MUL255_OVF_EN adds ovf.
// Ports: clk, rst (async active-high); bus (slave): start, q, busy, done, out[, ovf].
module mul255_serial
    import mul255_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mul255_serial_if.slave  bus
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] q_q, q_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              borrow_q, borrow_d;
`ifdef MUL255_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [BYTE_W-1:0] sub_a, sub_b, sub_d;
    logic              sub_bout;
    logic [WORD_W-1:0] q_shl;
    int unsigned       lo;

    // Minuend is q<<8, so the byte in lane k is byte k-1 of q (zero for lane 0).
    assign q_shl = {q_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    assign lo    = byte_lo(state_q);
    assign sub_a = q_shl[lo +: BYTE_W];
    assign sub_b = q_q[lo +: BYTE_W];

    mul255_byte_sub u_sub (
        .a_i    (sub_a),
        .b_i    (sub_b),
        .bin_i  (borrow_q),
        .d_o    (sub_d),
        .bout_o (sub_bout)
    );

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        out_d    = out_q;
        borrow_d = borrow_q;
`ifdef MUL255_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_B0;
                    q_d      = bus.q;
                    out_d    = '0;
                    borrow_d = 1'b0;
`ifdef MUL255_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            S_B0, S_B1, S_B2, S_B3: begin
                out_d[lo +: BYTE_W] = sub_d;
                borrow_d            = sub_bout;
                case (state_q)
                    S_B0:    state_d = S_B1;
                    S_B1:    state_d = S_B2;
                    S_B2:    state_d = S_B3;
                    default: state_d = S_DONE;
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef MUL255_OVF_EN
                // Bits 39:32 of the exact product: top byte of q minus the last borrow.
                ovf_d = (q_q[WORD_W-1 -: BYTE_W] - {{(BYTE_W-1){1'b0}}, borrow_q}) != '0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            out_q    <= '0;
            borrow_q <= 1'b0;
`ifdef MUL255_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            out_q    <= out_d;
            borrow_q <= borrow_d;
`ifdef MUL255_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.out  = out_q;
`ifdef MUL255_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_mul255_serial.sv
// Bench for mul255_serial: random and directed operands against an exact q*255 model.
// Latency: expects done in cycle 5 counting the start-sample cycle as cycle 0.
// Backpressure: exercises start while busy, reset mid-operation and held start.
module tb_mul255_serial;

    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul255_serial_if bus ();

    mul255_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact product; out is its low word, ovf means the high word is non-zero.
    function automatic logic [63:0] ref_prod(input logic [31:0] qv);
        return {32'd0, qv} * 64'd255;
    endfunction

    function automatic logic [31:0] ref_out(input logic [31:0] qv);
        logic [63:0] p;
        p = ref_prod(qv);
        return p[31:0];
    endfunction

    function automatic logic ref_ovf(input logic [31:0] qv);
        logic [63:0] p;
        p = ref_prod(qv);
        return p[63:32] != 32'd0;
    endfunction

    task automatic run_op(input logic [31:0] qv, input string tag);
        int          done_cyc;
        int          busy_cnt;
        int          pulses;
        logic [31:0] got_out;
        logic        got_ovf;
        done_cyc = 0;
        busy_cnt = 0;
        pulses   = 0;
        got_out  = 32'hDEAD_BEEF;
        got_ovf  = 1'b0;
        @(negedge clk);
        check({tag, ".idle_busy"}, bus.busy, 0);
        bus.start = 1'b1;
        bus.q     = qv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.q     = $urandom;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                pulses++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    got_out  = bus.out;
`ifdef MUL255_OVF_EN
                    got_ovf  = bus.ovf;
`endif
                end
            end
        end
        check({tag, ".latency"}, done_cyc, LAT);
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".busy_cycles"}, busy_cnt, LAT);
        check({tag, ".out"}, got_out, ref_out(qv));
        check({tag, ".out_held"}, bus.out, ref_out(qv));
`ifdef MUL255_OVF_EN
        check({tag, ".ovf"}, got_ovf, ref_ovf(qv));
        check({tag, ".ovf_held"}, bus.ovf, ref_ovf(qv));
`else
        if (got_ovf) check({tag, ".ovf_absent"}, got_ovf, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] qv;
        logic [31:0] outs [$];
        int          cycs [$];
        int          pulses;
        int          done_cyc;
        logic [31:0] got_out;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.q     = 32'h0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.q     = 32'hA5A5_A5A5;
        @(negedge clk);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.out", bus.out, 0);
`ifdef MUL255_OVF_EN
        check("rst.ovf", bus.ovf, 0);
`endif
        bus.start = 1'b0;
        rst       = 1'b0;

        // Directed corner operands.
        run_op(32'h0000_0001, "q1");
        check("q1.lit", bus.out, 32'h0000_00FF);
        run_op(32'h0101_0101, "q01010101");
        check("q01010101.lit", bus.out, 32'hFFFF_FFFF);
        run_op(32'h0101_0102, "q01010102");
        check("q01010102.lit", bus.out, 32'h0000_00FE);
        run_op(32'hFFFF_FFFF, "qffffffff");
        check("qffffffff.lit", bus.out, 32'hFFFF_FF01);
        run_op(32'h0000_0000, "q0");
        check("q0.lit", bus.out, 32'h0);
        run_op(32'h00FF_FFFF, "q00ffffff");

        // Random operands: full range and small values.
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) qv = $urandom_range(0, 1023);
            else            qv = $urandom;
            run_op(qv, $sformatf("rnd%0d", i));
        end

        // Start pulsed during B2 with a new operand must be ignored.
        qv = $urandom;
        @(negedge clk);
        bus.start = 1'b1;
        bus.q     = qv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.q     = $urandom;
        pulses    = 0;
        done_cyc  = 0;
        got_out   = 32'hDEAD_BEEF;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    got_out  = bus.out;
                end
            end
            if (c == 3) begin
                bus.start = 1'b1;
                bus.q     = 32'h1234_5678;
            end else if (c == 4) begin
                bus.start = 1'b0;
            end
        end
        check("ign.pulses", pulses, 1);
        check("ign.latency", done_cyc, LAT);
        check("ign.out", got_out, ref_out(qv));
        check("ign.idle", bus.busy, 0);

        // Reset during B1 aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.q     = 32'h0000_0007;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.busy", bus.busy, 0);
        check("abort.out", bus.out, 0);
        check("abort.done", bus.done, 0);
`ifdef MUL255_OVF_EN
        check("abort.ovf", bus.ovf, 0);
`endif
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort.no_done", pulses, 0);
        run_op(32'h0000_0002, "post_rst");
        check("post_rst.lit", bus.out, 32'h0000_01FE);

        // Start held high for 12 edges: two operations, one IDLE cycle apart.
        @(negedge clk);
        bus.start = 1'b1;
        bus.q     = 32'h0000_0003;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.done) begin
                cycs.push_back(c);
                outs.push_back(bus.out);
            end
            if (c == 12) bus.start = 1'b0;
        end
        check("b2b.pulses", cycs.size(), 2);
        if (cycs.size() == 2) begin
            check("b2b.first", cycs[0], LAT);
            check("b2b.gap", cycs[1] - cycs[0], 6);
            check("b2b.out0", outs[0], 32'h0000_02FD);
            check("b2b.out1", outs[1], 32'h0000_02FD);
        end
        check("b2b.idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
